// File: rtl/keypad_emulator.sv
// 4x4 keypad model. It answers an active-low row scan with active-high column lines and plays
// scripted presses with optional LFSR-driven contact bounce.
module keypad_emulator #(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 1024,
  parameter int unsigned CNT_W         = 16,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  input  logic       press_req,
  input  logic [3:0] press_key,
  input  logic       bounce_en,
  output logic [3:0] col,
  output logic       busy,
  output logic       done,
  output logic [3:0] key_q
);

  localparam logic [7:0]       SeedEff    = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam bit               HasBounce  = (BOUNCE_CYCLES > 0);
  localparam logic [CNT_W-1:0] BounceLoad =
      CNT_W'((BOUNCE_CYCLES > 0) ? (BOUNCE_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] HoldLoad   =
      CNT_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    StIdle,
    StMakeBounce,
    StHold,
    StBreakBounce
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lfsr_q, lfsr_d, lfsr_shift;
  logic             bounce_q, bounce_d;
  logic             done_q, done_d;
  logic [3:0]       key_d;
  logic             contact;
  logic [1:0]       key_row, key_col;

  // Taps x^8+x^6+x^5+x^4+1; maximal length, so a nonzero seed never reaches zero.
  assign lfsr_shift = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    bounce_d = bounce_q;
    done_d   = 1'b0;
    key_d    = key_q;
    contact  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press_req) begin
          key_d    = press_key;
          bounce_d = bounce_en && HasBounce;
          if (bounce_en && HasBounce) begin
            state_d = StMakeBounce;
            cnt_d   = BounceLoad;
          end else begin
            state_d = StHold;
            cnt_d   = HoldLoad;
          end
        end
      end
      StMakeBounce: begin
        contact = lfsr_q[0];
        lfsr_d  = lfsr_shift;
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StHold: begin
        contact = 1'b1;
        if (cnt_q == '0) begin
          if (bounce_q) begin
            state_d = StBreakBounce;
            cnt_d   = BounceLoad;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StBreakBounce: begin
        contact = lfsr_q[0];
        lfsr_d  = lfsr_shift;
        if (cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      lfsr_q   <= SeedEff;
      bounce_q <= 1'b0;
      done_q   <= 1'b0;
      key_q    <= 4'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      bounce_q <= bounce_d;
      done_q   <= done_d;
      key_q    <= key_d;
    end
  end

  // Physical position of the latched key: row index and column bit.
  always_comb begin
    key_row = 2'd0;
    key_col = 2'd0;
    unique case (key_q)
      4'h1: begin key_row = 2'd0; key_col = 2'd0; end
      4'h2: begin key_row = 2'd0; key_col = 2'd1; end
      4'h3: begin key_row = 2'd0; key_col = 2'd2; end
      4'hA: begin key_row = 2'd0; key_col = 2'd3; end
      4'h4: begin key_row = 2'd1; key_col = 2'd0; end
      4'h5: begin key_row = 2'd1; key_col = 2'd1; end
      4'h6: begin key_row = 2'd1; key_col = 2'd2; end
      4'hB: begin key_row = 2'd1; key_col = 2'd3; end
      4'h7: begin key_row = 2'd2; key_col = 2'd0; end
      4'h8: begin key_row = 2'd2; key_col = 2'd1; end
      4'h9: begin key_row = 2'd2; key_col = 2'd2; end
      4'hC: begin key_row = 2'd2; key_col = 2'd3; end
      4'hF: begin key_row = 2'd3; key_col = 2'd0; end
      4'h0: begin key_row = 2'd3; key_col = 2'd1; end
      4'hE: begin key_row = 2'd3; key_col = 2'd2; end
      4'hD: begin key_row = 2'd3; key_col = 2'd3; end
      default: ;
    endcase
  end

  assign col  = (contact && !row_n[key_row]) ? 4'(4'b0001 << key_col) : 4'b0000;
  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed self-checking bench for keypad_emulator: scan responses, press timing, bounce
// sequence, request filtering and mid-press reset.
module tb_keypad_emulator;

  localparam int unsigned B = 16;
  localparam int unsigned H = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_n;
  logic       press_req;
  logic [3:0] press_key;
  logic       bounce_en;
  logic [3:0] col;
  logic       busy;
  logic       done;
  logic [3:0] key_q;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] m_lfsr;

  // {row, col bit} of each key, indexed by key value.
  logic [3:0] kpos [16] = '{4'hD, 4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8,
                            4'h9, 4'hA, 4'h3, 4'h7, 4'hB, 4'hF, 4'hE, 4'hC};
  logic [3:0] rows [6]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0000, 4'b1111};

  keypad_emulator #(
    .BOUNCE_CYCLES(B),
    .HOLD_CYCLES  (H),
    .CNT_W        (16),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row_n    (row_n),
    .press_req(press_req),
    .press_key(press_key),
    .bounce_en(bounce_en),
    .col      (col),
    .busy     (busy),
    .done     (done),
    .key_q    (key_q)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish within bound");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_col(input logic [3:0] key, input logic contact,
                                         input logic [3:0] rown);
    logic [3:0] p;
    p = kpos[key];
    if (contact && !rown[p[3:2]]) return 4'(4'b0001 << p[1:0]);
    return 4'b0000;
  endfunction

  // Called just after a falling edge; returns at the falling edge following acceptance.
  task automatic start_press(input logic [3:0] key, input logic bnc);
    press_req = 1'b1;
    press_key = key;
    bounce_en = bnc;
    @(negedge clk);
    press_req = 1'b0;
    press_key = ~key;
    bounce_en = ~bnc;
  endtask

  // Walks every busy cycle against the model; returns 1 ns into the done cycle.
  task automatic run_press(input logic [3:0] key, input logic bnc, input logic rot,
                           input logic [3:0] fixed_row, input logic inj_mid);
    int unsigned total;
    logic        bounce_ph, ct;
    total = bnc ? (2 * B + H) : H;
    for (int i = 0; i < int'(total); i++) begin
      row_n = rot ? rows[i % 6] : fixed_row;
      if (inj_mid && i == 4) begin
        press_req = 1'b1;
        press_key = 4'h9;
      end
      if (inj_mid && i == 5) press_req = 1'b0;
      #1;
      bounce_ph = bnc && (i < int'(B) || i >= int'(B + H));
      ct = bounce_ph ? m_lfsr[0] : 1'b1;
      check_eq("busy_in_press", 32'(busy), 32'd1);
      check_eq("done_in_press", 32'(done), 32'd0);
      check_eq("key_q_stable", 32'(key_q), 32'(key));
      check_eq("col_in_press", 32'(col), 32'(exp_col(key, ct, row_n)));
      if (bounce_ph) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      @(negedge clk);
    end
    row_n = 4'b0000;
    #1;
    check_eq("busy_end", 32'(busy), 32'd0);
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("col_end", 32'(col), 32'd0);
    check_eq("key_q_end", 32'(key_q), 32'(key));
  endtask

  task automatic after_done();
    @(negedge clk);
    #1;
    check_eq("done_single", 32'(done), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    row_n     = 4'b1110;
    press_req = 1'b0;
    press_key = 4'h0;
    bounce_en = 1'b0;
    m_lfsr    = 8'hA5;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_col", 32'(col), 32'd0);
    check_eq("rst_key_q", 32'(key_q), 32'd0);
    reset = 1'b0;

    // Idle with no press
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      check_eq("idle_col", 32'(col), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_done", 32'(done), 32'd0);
    end

    // No-bounce presses, rows rotating
    start_press(4'h5, 1'b0);
    run_press(4'h5, 1'b0, 1'b1, 4'b1110, 1'b0);
    after_done();
    start_press(4'hD, 1'b0);
    run_press(4'hD, 1'b0, 1'b1, 4'b1110, 1'b0);
    after_done();

    // Request mid-hold ignored; request on the done cycle accepted
    start_press(4'h6, 1'b0);
    run_press(4'h6, 1'b0, 1'b1, 4'b1110, 1'b1);
    start_press(4'h3, 1'b0);
    run_press(4'h3, 1'b0, 1'b1, 4'b1110, 1'b0);
    after_done();

    // Bounce press from the reset seed, row 0 driven
    start_press(4'h1, 1'b1);
    run_press(4'h1, 1'b1, 1'b0, 4'b1110, 1'b0);
    after_done();

    // Reset during HOLD after the LFSR has advanced
    start_press(4'h6, 1'b1);
    repeat (B + 5) @(negedge clk);
    row_n = 4'b0000;
    #1;
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    check_eq("pre_rst_col", 32'(col), 32'b0100);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_col", 32'(col), 32'd0);
    check_eq("midrst_key_q", 32'(key_q), 32'd0);
    reset  = 1'b0;
    m_lfsr = 8'hA5;
    @(negedge clk);
    #1;
    check_eq("postrst_done", 32'(done), 32'd0);
    check_eq("postrst_busy", 32'(busy), 32'd0);
    start_press(4'hB, 1'b1);
    run_press(4'hB, 1'b1, 1'b1, 4'b1110, 1'b0);
    after_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
